alu_md_controller: RTL and testbench
====================================

Name: alu_md_controller

Overview:
- Second-generation ALU controller for the MIPS core.
- Decodes opcode/funct into an ALUType::alu_cmd_t command for the extended R/I integer set.
- Contains an iterative multiply/divide unit (MDU) that owns the HI/LO registers.
- Produces a stall handshake so the core holds an instruction while the MDU is busy.
- Sits between instruction decode and the ALU/register-writeback mux.

Parameters:
XLEN, 32, datapath width of operands, HI and LO; must be even and at least 8.
CNT_W, $clog2(XLEN+1), width of the iteration counter (derived; not overridden).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
valid_in  in  1  the instruction on opcode/funct is live this cycle.
opcode  in  6  instruction opcode (CPUType::opcode_t).
funct  in  6  R-type funct (CPUType::funct_t).
rs_val  in  XLEN  rs operand; dividend/multiplicand.
rt_val  in  XLEN  rt operand; divisor/multiplier.
alu_cmd_out  out  alu_cmd_t  combinational ALU command.
wb_sel  out  2  writeback source: 0=ALU, 1=HI, 2=LO.
stall  out  1  combinational; core must hold the current instruction.
md_busy  out  1  registered; MDU state is not IDLE.
hi_out  out  XLEN  HI register.
lo_out  out  XLEN  LO register.

Behaviour:
- Decode (combinational, independent of valid_in):
  - R-type: add/addu→ADD, sub/subu→SUB, and→AND, or→OR, xor→XOR, nor→NOR, sll/sllv→SLL, srl/srlv→SRL, sra/srav→SRA, slt→LESS_THAN, sltu→LESS_THAN_U.
  - I-type: addi/addiu→ADD, andi→AND, ori→OR, xori→XOR, slti→LESS_THAN, sltiu→LESS_THAN_U, lui→LUI, beq/bne→EQUAL.
  - Everything else→NONE. The ALUType package gains XOR, NOR, SRA, LESS_THAN_U and LUI.
- mult(0x18), multu(0x19), div(0x1A), divu(0x1B), mfhi(0x10) and mflo(0x12) produce alu_cmd_out=NONE.
- wb_sel is 1 for mfhi, 2 for mflo, 0 otherwise.
- MDU FSM states are IDLE, RUN and FIX.
  - IDLE→RUN when valid_in is high with an MD op and stall is low. Operands are latched: magnitudes for signed ops, raw values for unsigned ops. Sign flags and op type are also latched; cnt=0.
  - RUN performs one shift-add (multiply) or one restoring-subtract (divide) step per cycle. After XLEN RUN cycles it goes to FIX.
  - FIX applies signs and writes HI/LO, then returns to IDLE.
- Latency: accept at edge T; HI/LO valid after edge T+XLEN+1; md_busy high from T+1 to T+XLEN+1 inclusive.
- stall = valid_in & (MD op | mfhi | mflo) & md_busy. The issuing MD instruction itself never stalls. A back-to-back MD op or an mfhi/mflo stalls until the FSM is IDLE.
- Sign rules:
  - Signed product is negated when the operand signs differ.
  - Signed quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - mult/multu: HI = upper XLEN bits, LO = lower XLEN bits. div/divu: LO = quotient, HI = remainder.
- Divide by zero: no trap; runs the full latency. Result is LO = all ones and HI = dividend, with the signed fix-up applied as normal.
- Most-negative ÷ −1 (signed): LO = most-negative value, HI = 0.
- Reset, including mid-operation: state IDLE, cnt=0, HI=0, LO=0, md_busy=0. Any in-flight operation is discarded.
- Operands are sampled only at acceptance; later changes to rs_val/rt_val have no effect.

Optional Feature:
Macro ALU_MTHILO_EN.
- Defined:
  - mthi (0x11) and mtlo (0x13) write rs_val to HI or LO at the next edge when the FSM is IDLE.
  - Both stall while md_busy. alu_cmd_out=NONE and wb_sel=0 for these instructions.
  - A write in the same cycle that FIX updates HI/LO cannot occur, because stall blocks it.
- Undefined: 0x11/0x13 decode to NONE, HI/LO are unaffected, and stall stays low for them.

Test Plan:
- Reset then decode sweep: every listed opcode/funct → the specified alu_cmd_out/wb_sel; an undefined funct (0x3F) → NONE, 0.
- mult rs=0xFFFF_FFFE (−2), rt=3 → after XLEN+1 edges HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. With multu instead → HI=0x0000_0002, LO=0xFFFF_FFFA.
- div rs=−7, rt=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. divu rs=7, rt=0 → LO=0xFFFF_FFFF, HI=7.
- div rs=0x8000_0000, rt=0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- mult issued, then mflo on the next cycle with valid_in held → stall=1 for exactly XLEN+1 cycles, then stall=0, wb_sel=2 and lo_out holds the product.
- rst asserted at RUN cycle 10 of a divu → next cycle md_busy=0, HI=LO=0; a new mult is accepted on the following cycle.

Source files
------------

// File: rtl/ALUType.sv
// ALUType: ALU command encoding shared by the decoder and the ALU datapath.
package ALUType;
    typedef enum logic [3:0] {
        NONE, ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA,
        LESS_THAN, LESS_THAN_U, LUI, EQUAL
    } alu_cmd_t;
endpackage

// File: rtl/alu_md_controller.sv
// alu_md_controller: MIPS ALU command decoder plus iterative multiply/divide unit owning HI/LO.
//   clk, rst            : clock, synchronous active-high reset
//   valid_in            : instruction on opcode/funct is live
//   opcode, funct       : instruction fields
//   rs_val, rt_val      : operands (dividend/multiplicand, divisor/multiplier)
//   alu_cmd_out, wb_sel : decoded ALU command and writeback source (0=ALU, 1=HI, 2=LO)
//   stall               : hold the current instruction while the MDU is busy
//   md_busy             : MDU is not idle
//   hi_out, lo_out      : HI/LO registers
// Optional macro ALU_MTHILO_EN adds mthi/mtlo writes to HI/LO.
module alu_md_controller #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [XLEN-1:0]   rs_val,
    input  logic [XLEN-1:0]   rt_val,
    output ALUType::alu_cmd_t alu_cmd_out,
    output logic [1:0]        wb_sel,
    output logic              stall,
    output logic              md_busy,
    output logic [XLEN-1:0]   hi_out,
    output logic [XLEN-1:0]   lo_out
);
    import ALUType::*;
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [2*XLEN-1:0] acc, acc_step, prod_fix;
    logic [XLEN-1:0] opb, a_mag, b_mag, d_diff, quo_fix, rem_fix;
    logic [XLEN:0] m_sum, d_sh;
    logic op_div, neg_q, neg_r, s_a, s_b;
    logic r_type, is_mult, is_div, is_md, is_mfhi, is_mflo, is_mthi, is_mtlo, accept;

    assign r_type  = opcode == 6'h00;
    assign is_mult = r_type && funct[5:1] == 5'h0C;
    assign is_div  = r_type && funct[5:1] == 5'h0D;
    assign is_md   = is_mult | is_div;
    assign is_mfhi = r_type && funct == 6'h10;
    assign is_mflo = r_type && funct == 6'h12;
`ifdef ALU_MTHILO_EN
    assign is_mthi = r_type && funct == 6'h11;
    assign is_mtlo = r_type && funct == 6'h13;
`else
    assign is_mthi = 1'b0;
    assign is_mtlo = 1'b0;
`endif
    assign stall  = valid_in & (is_md | is_mfhi | is_mflo | is_mthi | is_mtlo) & md_busy;
    assign accept = valid_in & is_md & ~stall & (state == IDLE);
    assign wb_sel = is_mfhi ? 2'd1 : is_mflo ? 2'd2 : 2'd0;

    // funct[0] clear selects the signed variant (mult/div); work on magnitudes
    assign s_a   = ~funct[0] & rs_val[XLEN-1];
    assign s_b   = ~funct[0] & rt_val[XLEN-1];
    assign a_mag = s_a ? -rs_val : rs_val;
    assign b_mag = s_b ? -rt_val : rt_val;

    // multiply: acc = {partial product, remaining multiplier}, shifting right
    assign m_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? opb : {XLEN{1'b0}}};
    // divide: acc = {remainder, dividend/quotient}, shifting left; a zero divisor
    // always subtracts, giving an all-ones quotient and the dividend as remainder
    assign d_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign d_diff = d_sh[XLEN-1:0] - opb;
    assign acc_step = !op_div ? {m_sum, acc[XLEN-1:1]}
                    : d_sh >= {1'b0, opb} ? {d_diff, acc[XLEN-2:0], 1'b1}
                    : {d_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        alu_cmd_out = NONE;
        if (r_type) begin
            case (funct)
                6'h20, 6'h21: alu_cmd_out = ADD;
                6'h22, 6'h23: alu_cmd_out = SUB;
                6'h24:        alu_cmd_out = AND;
                6'h25:        alu_cmd_out = OR;
                6'h26:        alu_cmd_out = XOR;
                6'h27:        alu_cmd_out = NOR;
                6'h00, 6'h04: alu_cmd_out = SLL;
                6'h02, 6'h06: alu_cmd_out = SRL;
                6'h03, 6'h07: alu_cmd_out = SRA;
                6'h2A:        alu_cmd_out = LESS_THAN;
                6'h2B:        alu_cmd_out = LESS_THAN_U;
                default:      alu_cmd_out = NONE;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09: alu_cmd_out = ADD;
                6'h0C:        alu_cmd_out = AND;
                6'h0D:        alu_cmd_out = OR;
                6'h0E:        alu_cmd_out = XOR;
                6'h0A:        alu_cmd_out = LESS_THAN;
                6'h0B:        alu_cmd_out = LESS_THAN_U;
                6'h0F:        alu_cmd_out = LUI;
                6'h04, 6'h05: alu_cmd_out = EQUAL;
                default:      alu_cmd_out = NONE;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? RUN : IDLE;
            RUN:     state_n = cnt == LAST ? FIX : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
            md_busy <= 1'b0;
        end else begin
            md_busy <= state_n != IDLE;
            if (accept) begin
                acc    <= {{XLEN{1'b0}}, a_mag};
                opb    <= b_mag;
                op_div <= is_div;
                neg_q  <= s_a ^ s_b;
                neg_r  <= s_a;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                hi_out <= op_div ? rem_fix : prod_fix[2*XLEN-1:XLEN];
                lo_out <= op_div ? quo_fix : prod_fix[XLEN-1:0];
            end else if (valid_in && state == IDLE) begin
                if (is_mthi) hi_out <= rs_val;
                if (is_mtlo) lo_out <= rs_val;
            end
        end
    end
endmodule

// File: tb/tb_alu_md_controller.sv
// tb_alu_md_controller: randomized self-checking bench for alu_md_controller against an arithmetic model.
module tb_alu_md_controller;
    import ALUType::*;
    logic clk = 1'b0;
    logic rst, valid_in, stall, md_busy;
    logic [5:0] opcode, funct;
    logic [31:0] rs_val, rt_val, hi_out, lo_out;
    logic [1:0] wb_sel;
    alu_cmd_t alu_cmd_out;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        alu_cmd_t   cmd;
        logic [1:0] wb;
    } dec_t;

    alu_md_controller #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .alu_cmd_out(alu_cmd_out), .wb_sel(wb_sel),
        .stall(stall), .md_busy(md_busy), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    // {HI, LO} from plain 64-bit / 32-bit arithmetic
    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            6'h18: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            6'h19: return {32'd0, a} * {32'd0, b};
            6'h1B: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
        endcase
    endfunction

    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        int n;
        logic [63:0] exp;
        exp = md_model(f, a, b);
        valid_in = 1'b1; opcode = 6'h00; funct = f; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        valid_in = 1'b0; rs_val = $urandom; rt_val = $urandom;
        n = 0;
        while (md_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL latency f=%h: busy %0d cycles, want 33", f, n);
        end
        checks++;
        if ({hi_out, lo_out} !== exp) begin
            errors++;
            $display("FAIL result f=%h a=%h b=%h: hi/lo=%h_%h, want %h_%h", f, a, b, hi_out, lo_out, exp[63:32], exp[31:0]);
        end
        hi = hi_out;
        lo = lo_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; opcode = 6'h00; funct = 6'h00; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({md_busy, hi_out, lo_out} !== 65'd0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h, want 0 0 0", md_busy, hi_out, lo_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        dec_t t[$];
        t.push_back(dec_t'{6'h00, 6'h20, ADD, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h21, ADD, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h22, SUB, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h23, SUB, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h24, AND, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h25, OR, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h26, XOR, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h27, NOR, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h00, SLL, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h04, SLL, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h02, SRL, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h06, SRL, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h03, SRA, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h07, SRA, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h2A, LESS_THAN, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h2B, LESS_THAN_U, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h18, NONE, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h19, NONE, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h1A, NONE, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h1B, NONE, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h10, NONE, 2'd1});
        t.push_back(dec_t'{6'h00, 6'h12, NONE, 2'd2});
        t.push_back(dec_t'{6'h00, 6'h11, NONE, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h13, NONE, 2'd0});
        t.push_back(dec_t'{6'h00, 6'h3F, NONE, 2'd0});
        t.push_back(dec_t'{6'h08, 6'h00, ADD, 2'd0});
        t.push_back(dec_t'{6'h09, 6'h00, ADD, 2'd0});
        t.push_back(dec_t'{6'h0C, 6'h00, AND, 2'd0});
        t.push_back(dec_t'{6'h0D, 6'h00, OR, 2'd0});
        t.push_back(dec_t'{6'h0E, 6'h00, XOR, 2'd0});
        t.push_back(dec_t'{6'h0A, 6'h00, LESS_THAN, 2'd0});
        t.push_back(dec_t'{6'h0B, 6'h00, LESS_THAN_U, 2'd0});
        t.push_back(dec_t'{6'h0F, 6'h00, LUI, 2'd0});
        t.push_back(dec_t'{6'h04, 6'h00, EQUAL, 2'd0});
        t.push_back(dec_t'{6'h05, 6'h00, EQUAL, 2'd0});
        t.push_back(dec_t'{6'h23, 6'h00, NONE, 2'd0});
        t.push_back(dec_t'{6'h02, 6'h00, NONE, 2'd0});
        valid_in = 1'b0;
        foreach (t[i]) begin
            opcode = t[i].op;
            funct = t[i].op == 6'h00 ? t[i].fn : 6'($urandom_range(0, 63));
            rs_val = $urandom; rt_val = $urandom;
            #1;
            checks++;
            if (alu_cmd_out !== t[i].cmd || wb_sel !== t[i].wb) begin
                errors++;
                $display("FAIL decode op=%h fn=%h: cmd=%0d wb=%0d, want cmd=%0d wb=%0d", opcode, funct, alu_cmd_out, wb_sel, t[i].cmd, t[i].wb);
            end
        end
        funct = 6'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] h, l;
        run_md(6'h18, 32'hFFFF_FFFE, 32'd3, h, l);
        checks++;
        if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult -2*3: %h_%h", h, l); end
        run_md(6'h19, 32'hFFFF_FFFE, 32'd3, h, l);
        checks++;
        if ({h, l} !== 64'h0000_0002_FFFF_FFFA) begin errors++; $display("FAIL multu: %h_%h", h, l); end
        run_md(6'h1A, 32'hFFFF_FFF9, 32'd2, h, l);
        checks++;
        if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div -7/2: %h_%h", h, l); end
        run_md(6'h1B, 32'd7, 32'd0, h, l);
        checks++;
        if ({h, l} !== 64'h0000_0007_FFFF_FFFF) begin errors++; $display("FAIL divu 7/0: %h_%h", h, l); end
        run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, h, l);
        checks++;
        if ({h, l} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div minneg/-1: %h_%h", h, l); end
    endtask

    task automatic test_random();
        logic [31:0] h, l, a, b;
        logic [5:0] f;
        repeat (30) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            run_md(f, a, b, h, l);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] a, b;
        logic [63:0] exp;
        a = $urandom; b = $urandom;
        exp = md_model(6'h18, a, b);
        valid_in = 1'b1; opcode = 6'h00; funct = 6'h18; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        funct = 6'h12; rs_val = $urandom;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL mflo stall: %0d cycles, want 33", n); end
        checks++;
        if (wb_sel !== 2'd2) begin errors++; $display("FAIL mflo wb_sel: %0d, want 2", wb_sel); end
        checks++;
        if ({hi_out, lo_out} !== exp) begin errors++; $display("FAIL mflo product: %h_%h, want %h", hi_out, lo_out, exp); end
        valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] a, b, c, d;
        logic [63:0] exp_m, exp_d;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
        exp_m = md_model(6'h18, a, b);
        exp_d = md_model(6'h1A, c, d);
        valid_in = 1'b1; opcode = 6'h00; funct = 6'h18; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        funct = 6'h1A; rs_val = c; rt_val = d;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL b2b stall: %b, want 1", stall); end
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL b2b stall length: %0d, want 33", n); end
        checks++;
        if ({hi_out, lo_out} !== exp_m) begin errors++; $display("FAIL b2b mult: %h_%h, want %h", hi_out, lo_out, exp_m); end
        @(posedge clk); #1;
        valid_in = 1'b0; rs_val = $urandom; rt_val = $urandom;
        n = 0;
        while (md_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL b2b div latency: %0d, want 33", n); end
        checks++;
        if ({hi_out, lo_out} !== exp_d) begin errors++; $display("FAIL b2b div: %h_%h, want %h", hi_out, lo_out, exp_d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        run_md(6'h19, 32'h1234_5678, 32'h10, h, l);
        valid_in = 1'b1; opcode = 6'h00; funct = 6'h1B; rs_val = $urandom; rt_val = $urandom_range(1, 99);
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({md_busy, hi_out, lo_out} !== 65'd0) begin
            errors++;
            $display("FAIL mid reset: busy=%b hi=%h lo=%h, want 0 0 0", md_busy, hi_out, lo_out);
        end
        rst = 1'b0;
        run_md(6'h18, $urandom, $urandom, h, l);
    endtask

    task automatic test_mthilo();
        int n;
        logic [31:0] x, y, h0, l0;
        logic [63:0] exp;
        x = $urandom; y = $urandom;
        h0 = hi_out; l0 = lo_out;
        valid_in = 1'b1; opcode = 6'h00; funct = 6'h11; rs_val = x;
        @(posedge clk); #1;
        funct = 6'h13; rs_val = y;
        @(posedge clk); #1;
        valid_in = 1'b0;
`ifdef ALU_MTHILO_EN
        checks++;
        if ({hi_out, lo_out} !== {x, y}) begin errors++; $display("FAIL mthi/mtlo: %h_%h, want %h_%h", hi_out, lo_out, x, y); end
`else
        checks++;
        if ({hi_out, lo_out} !== {h0, l0}) begin errors++; $display("FAIL mthi/mtlo ignored: %h_%h, want %h_%h", hi_out, lo_out, h0, l0); end
`endif
        exp = md_model(6'h19, x, y);
        valid_in = 1'b1; funct = 6'h19; rs_val = x; rt_val = y;
        @(posedge clk); #1;
        funct = 6'h11; rs_val = ~x;
        #1;
`ifdef ALU_MTHILO_EN
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL mthi stall: %b, want 1", stall); end
`else
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mthi no stall: %b, want 0", stall); end
`endif
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++;
        if ({hi_out, lo_out} !== exp) begin errors++; $display("FAIL mthi during mdu: %h_%h, want %h", hi_out, lo_out, exp); end
        @(posedge clk); #1;
        valid_in = 1'b0;
`ifdef ALU_MTHILO_EN
        checks++;
        if (hi_out !== ~x) begin errors++; $display("FAIL mthi after stall: %h, want %h", hi_out, ~x); end
`else
        checks++;
        if (hi_out !== exp[63:32]) begin errors++; $display("FAIL mthi after mdu: %h, want %h", hi_out, exp[63:32]); end
`endif
    endtask

    initial begin
        test_reset();
        test_decode();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_mthilo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
